// File: rtl/tick_prescaler_pkg.sv
// Shared types and constants for the tick prescaler: FSM encoding and the
// width of the tick tally that mirrors the downstream 4-bit counter period.
package tick_prescaler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

  localparam int TICK_CNT_W = 4;

  function automatic logic is_busy(input state_t s);
    is_busy = (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/tick_prescaler_counter.sv
// Loadable down-counter used as the prescale divider; load has priority over
// decrement and the zero flag is decoded from the held count.
module prescale_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Count state: load wins over enable, otherwise hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tick_prescaler.sv
// Programmable clock-enable generator with start/stop/pause control, emitting a
// one-cycle tick every div cycles plus a 4-bit wrapping tick tally.
module tick_prescaler
  import tick_prescaler_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_pause,
  input  logic                  i_div_load,
  input  logic [DIV_W-1:0]      i_div_in,
  output logic                  o_tick,
  output logic [TICK_CNT_W-1:0] o_tick_count,
  output logic                  o_busy,
  output logic [1:0]            o_state
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic                  r_tick;
  logic [TICK_CNT_W-1:0] r_tick_count;
  logic [DIV_W-1:0]      r_div;

  logic                  w_load;
  logic                  w_en;
  logic [DIV_W-1:0]      w_load_val;
  logic                  w_zero;
  logic [DIV_W-1:0]      w_div_m1;
  logic [DIV_W-1:0]      w_div_in_fix;
  logic                  w_run_hold;

  assign w_div_m1     = r_div - ONE;
  assign w_div_in_fix = (i_div_in == '0) ? ONE : i_div_in;
  // A start in RUN is a no-op that still outranks pause.
  assign w_run_hold   = i_pause && !i_start;

  // Prescale counter control: stop clears, start-from-idle and terminal count reload.
  always_comb begin
    w_load     = 1'b0;
    w_en       = 1'b0;
    w_load_val = w_div_m1;
    if (i_stop) begin
      w_load     = 1'b1;
      w_load_val = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) w_load = 1'b1;
          else         w_load = 1'b0;
        end
        ST_RUN: begin
          if (w_run_hold)  w_en = 1'b0;
          else if (w_zero) w_load = 1'b1;
          else             w_en = 1'b1;
        end
        default: begin
          w_load = 1'b0;
          w_en   = 1'b0;
        end
      endcase
    end
  end

  prescale_counter #(.W(DIV_W)) u_prescale_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_en       (w_en),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  // Control FSM with registered tick, tally and divide ratio.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_tick       <= 1'b0;
      r_tick_count <= '0;
      r_div        <= DIV_W'(DEFAULT_DIV);
    end else if (i_stop) begin
      r_state <= ST_IDLE;
      r_tick  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tick <= 1'b0;
          if (i_start) begin
            r_state      <= ST_RUN;
            r_tick_count <= '0;
          end else if (i_div_load) begin
            r_div <= w_div_in_fix;
          end else begin
            r_div <= r_div;
          end
        end
        ST_RUN: begin
          if (w_run_hold) begin
            r_state <= ST_PAUSED;
            r_tick  <= 1'b0;
          end else if (w_zero) begin
            r_tick       <= 1'b1;
            r_tick_count <= r_tick_count + TICK_CNT_W'(1);
          end else begin
            r_tick <= 1'b0;
          end
        end
        ST_PAUSED: begin
          r_tick <= 1'b0;
          if (i_start) r_state <= ST_RUN;
          else         r_state <= ST_PAUSED;
        end
        default: begin
          r_state <= ST_IDLE;
          r_tick  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tick       = r_tick;
  assign o_tick_count = r_tick_count;
  assign o_busy       = is_busy(r_state);
  assign o_state      = r_state;

endmodule

// File: doc/tick_prescaler.md
# tick_prescaler

Programmable clock-enable generator with start/stop/pause control. Divides `clk` by a run-time loadable ratio and emits a one-cycle `tick` that drives the enable of the downstream 4-bit down-counter stage. It also keeps a 4-bit tick tally whose wrap matches the counter's 16-state period. It sits directly upstream of the counter and turns the free-running system clock into a controlled count rate.

## Interface
- `DIV_W`, default 8: width of the divide ratio.
- `DEFAULT_DIV`, default 10: divide ratio after reset. Must be 1 .. 2^DIV_W-1.

- `clk`  in  1: the single clock. All state updates on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: begin counting from IDLE, or resume from PAUSED.
- `stop`  in  1: abort to IDLE. Highest priority.
- `pause`  in  1: freeze the prescaler while in RUN.
- `div_load`  in  1: load `div_in` into the divide register. Accepted in IDLE only.
- `div_in`  in  DIV_W: new divide ratio. 0 is treated as 1.
- `tick`  out  1: registered, one-cycle enable pulse to the counter stage.
- `tick_count`  out  4: ticks since last start from IDLE. Wraps 15->0.
- `busy`  out  1: high in RUN or PAUSED.
- `state`  out  2: FSM state, IDLE=00, RUN=01, PAUSED=10.

## Operation
- Registers:
  - `div`, DIV_W bits.
  - `pre_cnt`, DIV_W bits, counts down.
  - `state`.
  - `tick`.
  - `tick_count`.
- Reset values: `state`=IDLE, `pre_cnt`=0, `div`=DEFAULT_DIV, `tick`=0, `tick_count`=0, `busy`=0.
- Priority per edge: `stop` > `start` > `pause` > `div_load`.
- IDLE:
  - `div_load` sets `div <= (div_in==0) ? 1 : div_in`.
  - `start` sets `pre_cnt <= div-1`, `tick_count <= 0`, and moves to RUN. If `start` and `div_load` are both high, `start` wins and `div` is unchanged.
  - `pause` is ignored.
- RUN:
  - If `pre_cnt==0`: `tick <= 1` and `pre_cnt <= div-1`. On the same edge `tick_count` increments, mod 16.
  - Otherwise: `tick <= 0` and `pre_cnt <= pre_cnt-1`.
  - `pause` moves to PAUSED. `tick <= 0` and `pre_cnt` holds.
  - `div_load` is ignored.
- PAUSED:
  - `pre_cnt` and `tick_count` hold, and `tick` stays 0.
  - `start` returns to RUN with no reload; the countdown resumes where it stopped.
  - `div_load` is ignored.
- `stop`, from any state: `state` goes to IDLE, `pre_cnt <= 0`, `tick <= 0`. `tick_count` holds its value for readout.
- Simultaneous `start` and `stop` results in IDLE.
- `start` while already in RUN has no effect and does not restart the count.
- `busy` is decoded from the registered `state`.

## Timing
- Let `start` be sampled in IDLE at edge 0. With ratio D, the first `tick` is high from edge D to edge D+1. After that `tick` repeats every D cycles.
  - D=1: `tick` is high continuously from edge 1.
  - D=4: `tick` is high after edges 4, 8, 12, ...
- `tick_count` updates on the same edge that raises `tick`.
- A pause lasting P cycles delays all later ticks by P plus the pause/resume entry cycles. No tick is lost or duplicated.
- `stop` takes effect at the next edge. A `tick` already registered completes its single cycle only if `stop` is sampled later.
- Reset asserted mid-run clears all outputs immediately, with no clock needed. After release, the block waits in IDLE for `start`.
- `tick` is never high for two consecutive cycles unless D=1.

## Structure
- Package `tick_prescaler_pkg`:
  - `state_t` enum (IDLE, RUN, PAUSED; 2 bits).
  - `TICK_CNT_W = 4` constant.
- One natural sub-module, `prescale_counter`: a loadable down-counter with `load`, `en`, `load_val` and a `zero` flag. The FSM in `tick_prescaler` drives its `load`/`en`.

## Test plan
- Reset then `start` with default D=10 -> first `tick` after edge 10, then period 10. `tick_count` reads 1, 2, 3, ...
- `div_load` `div_in`=3 in IDLE, then `start`; run 20 ticks -> period 3. `tick_count` wraps 15->0 at tick 16 and reads 4 after tick 20.
- `div_in`=0 loaded, then `start` -> `tick` high every cycle from edge 1. `div_load` while in RUN -> period unchanged.
- D=5; `pause` with `pre_cnt`=2 for 7 cycles, then `start` -> next tick 3 cycles after resume. `busy`=1 throughout and `state`=10 while paused.
- `start` and `stop` in the same cycle from IDLE -> `state` stays 00, and no tick appears within 2D cycles.
- `rst` asserted mid-run between edges -> `tick`, `busy`, `tick_count` and `state` go to 0 immediately. After release, `div` equals DEFAULT_DIV.
